// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int UART_MIN_BITS = 5;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP_0,
      TX_STOP_1
   } tx_state_e;

   // Per-frame line format, captured when a frame starts.
   typedef struct packed {
      logic [3:0] nbits;
      logic       parity_en;
      logic       parity_odd;
      logic       stop_twice;
   } frame_cfg_t;

   // Limit a requested data-bit count to the range the datapath supports.
   function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int lo, input int hi);
      if (int'(req) < lo)
         return 4'(lo);
      else if (int'(req) > hi)
         return 4'(hi);
      else
         return req;
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Control, FIFO and line signals of the UART transmit engine.
// Latency: n/a (wiring only).
// Backpressure: FIFO side uses show-ahead data with a pop strobe from the engine.
// Ports: master = CPU/FIFO/pad side, slave = transmit engine.
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W
);
   logic              baud_tick;
   logic              tx_en;
   logic [3:0]        data_bits;
   logic              parity_en;
   logic              parity_odd;
   logic              stop_bit_twice;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_pop;
   logic              txd;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output baud_tick, tx_en, data_bits, parity_en, parity_odd, stop_bit_twice,
             fifo_empty, fifo_rdata,
      input  fifo_pop, txd, tx_busy, tx_done
   );

   modport slave (
      input  baud_tick, tx_en, data_bits, parity_en, parity_odd, stop_bit_twice,
             fifo_empty, fifo_rdata,
      output fifo_pop, txd, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx_shifter.sv
// Frame datapath: shift register, data-bit counter, parity accumulator and latched frame format.
// Latency: load/shift take effect on the next PCLK edge; outputs are registered state.
// Backpressure: none; driven entirely by the transmit FSM's load and shift strobes.
// Ports: load/word/cfg_in start a frame, shift_en advances one data bit;
//        data_bit, parity_bit, last_bit, parity_en, stop_twice feed the FSM.
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int MIN_BITS = UART_MIN_BITS
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] word,
   input  frame_cfg_t        cfg_in,
   output logic              data_bit,
   output logic              parity_bit,
   output logic              last_bit,
   output logic              parity_en,
   output logic              stop_twice
);

   logic [DATA_W-1:0] shift_q;
   logic [3:0]        cnt_q;
   logic              acc_q;
   logic              last_q;
   frame_cfg_t        cfg_q;
   logic [3:0]        nbits_load;

   assign nbits_load = clamp_bits(cfg_in.nbits, MIN_BITS, DATA_W);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         shift_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         last_q  <= 1'b0;
         cfg_q   <= '0;
      end else if (load) begin
         shift_q <= word;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         last_q  <= (nbits_load == 4'd1);
         cfg_q   <= '{nbits: nbits_load, parity_en: cfg_in.parity_en,
                      parity_odd: cfg_in.parity_odd, stop_twice: cfg_in.stop_twice};
      end else if (shift_en) begin
         shift_q <= shift_q >> 1;
         acc_q   <= acc_q ^ shift_q[0];
         cnt_q   <= cnt_q + 4'd1;
         // Flag marks that the bit now on the line is the final data bit.
         last_q  <= ((cnt_q + 4'd2) == cfg_q.nbits);
      end
   end

   assign data_bit   = shift_q[0];
   assign parity_bit = acc_q ^ cfg_q.parity_odd;
   assign last_bit   = last_q;
   assign parity_en  = cfg_q.parity_en;
   assign stop_twice = cfg_q.stop_twice;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: prefetches FIFO words into a hold register and serialises them onto txd.
// Latency: frame starts on the first baud tick after a word is held; txd lags each deciding tick edge by 1 PCLK.
// Backpressure: pops only while tx_en and the hold register is free; held word makes frames gapless.
// Ports: PCLK, PRESETn (async, active-low); bus.slave carries tick, config, FIFO and line signals.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int MIN_BITS = UART_MIN_BITS
) (
   input  logic     PCLK,
   input  logic     PRESETn,
   uart_tx_if.slave bus
);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] hold_q;
   logic              hold_vld_q;
   logic              txd_q, txd_d;
   logic              done_q;
   logic              pop;
   logic              load;
   logic              shift_en;
   logic              eof;
   frame_cfg_t        cfg_in;
   logic              data_bit, parity_bit, last_bit, cfg_parity_en, cfg_stop_twice;

   assign cfg_in = '{nbits: bus.data_bits, parity_en: bus.parity_en,
                     parity_odd: bus.parity_odd, stop_twice: bus.stop_bit_twice};

   // Prefetch uses the registered hold flag, so a pop can never coincide with a load.
   assign pop = bus.tx_en & ~bus.fifo_empty & ~hold_vld_q;

   uart_tx_shifter #(.DATA_W(DATA_W), .MIN_BITS(MIN_BITS)) u_shifter (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .load       (load),
      .shift_en   (shift_en),
      .word       (hold_q),
      .cfg_in     (cfg_in),
      .data_bit   (data_bit),
      .parity_bit (parity_bit),
      .last_bit   (last_bit),
      .parity_en  (cfg_parity_en),
      .stop_twice (cfg_stop_twice)
   );

   always_comb begin
      state_d  = state_q;
      txd_d    = 1'b1;
      load     = 1'b0;
      shift_en = 1'b0;
      eof      = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (bus.baud_tick && hold_vld_q) begin
               load    = 1'b1;
               state_d = TX_START;
            end
         end
         TX_START: begin
            txd_d = 1'b0;
            if (bus.baud_tick) state_d = TX_DATA;
         end
         TX_DATA: begin
            txd_d = data_bit;
            if (bus.baud_tick) begin
               shift_en = 1'b1;
               if (last_bit) state_d = cfg_parity_en ? TX_PARITY : TX_STOP_0;
            end
         end
         TX_PARITY: begin
            txd_d = parity_bit;
            if (bus.baud_tick) state_d = TX_STOP_0;
         end
         TX_STOP_0: begin
            if (bus.baud_tick) begin
               if (cfg_stop_twice) state_d = TX_STOP_1;
               else                eof     = 1'b1;
            end
         end
         TX_STOP_1: begin
            if (bus.baud_tick) eof = 1'b1;
         end
         default: state_d = TX_IDLE;
      endcase
      // A word already held at end of frame goes straight into a new start bit.
      if (eof) begin
         if (hold_vld_q) begin
            load    = 1'b1;
            state_d = TX_START;
         end else begin
            state_d = TX_IDLE;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= TX_IDLE;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         done_q  <= eof;
         if (pop) begin
            hold_q     <= bus.fifo_rdata;
            hold_vld_q <= 1'b1;
         end else if (load) begin
            hold_vld_q <= 1'b0;
         end
      end
   end

   assign bus.fifo_pop = pop;
   assign bus.txd      = txd_q;
   assign bus.tx_done  = done_q;
   assign bus.tx_busy  = (state_q != TX_IDLE) | hold_vld_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a line monitor decodes txd.
// Latency: bit periods of 16 PCLK; frames sampled mid-bit.
// Backpressure: bench FIFO is show-ahead and advances on fifo_pop.
module tb_uart_tx_engine;
   import uart_pkg::*;

   logic PCLK = 1'b0;
   logic PRESETn;

   uart_tx_if #(.DATA_W(8)) bus ();

   uart_tx_engine #(.DATA_W(8), .MIN_BITS(5)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pop_cnt  = 0;
   int bad_pop  = 0;
   int done_cnt = 0;
   bit mon_stop = 1'b0;

   always @(posedge PCLK) cyc <= cyc + 1;

   // Baud tick every 16 PCLK.
   logic [3:0] tdiv = '0;
   always @(posedge PCLK) tdiv <= tdiv + 4'd1;
   assign bus.baud_tick = (tdiv == 4'hF);

   // Show-ahead FIFO model.
   logic [7:0] fmem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   assign bus.fifo_rdata = fmem[rd_ptr % 64];

   always @(posedge PCLK) begin
      if (bus.fifo_pop) begin
         rd_ptr  <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
         if (!bus.tx_en) bad_pop <= bad_pop + 1;
      end
      if (bus.tx_done) done_cnt <= done_cnt + 1;
   end

   typedef struct {
      logic [11:0] bits;   // bit k = k-th bit on the line
      int          len;    // frame length in bit periods
      int          nchk;   // bits to compare (fewer for an aborted frame)
      bit          gap;    // must start exactly where the previous frame ended
      bit          abort;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_frame(input logic [11:0] bits, input int len, input int nchk,
                               input bit gap, input bit abort);
      exp_t e;
      e.bits = bits; e.len = len; e.nchk = nchk; e.gap = gap; e.abort = abort;
      sbq.push_back(e);
   endtask

   task automatic push_word(input logic [7:0] w);
      @(negedge PCLK);
      fmem[wr_ptr % 64] = w;
      wr_ptr++;
   endtask

   task automatic set_cfg(input logic [3:0] nb, input logic pe, input logic po, input logic st2);
      bus.data_bits      = nb;
      bus.parity_en      = pe;
      bus.parity_odd     = po;
      bus.stop_bit_twice = st2;
   endtask

   task automatic wait_start(output int s);
      int n = 0;
      while (bus.txd !== 1'b0 && n < 1000) begin
         @(negedge PCLK);
         n++;
      end
      chk("start_seen", bus.txd, 1'b0);
      s = cyc;
   endtask

   task automatic wait_dones(input int target);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge PCLK);
         n++;
      end
      chk("done_count", done_cnt, target);
   endtask

   // Line monitor: decodes each frame mid-bit and checks it against the scoreboard.
   initial begin : monitor
      exp_t        e;
      int          s, prev_end, n;
      logic [11:0] cap, mask;
      prev_end = -1;
      repeat (4) @(negedge PCLK);
      forever begin
         while (bus.txd !== 1'b0 && !mon_stop) @(negedge PCLK);
         if (mon_stop) break;
         s = cyc;
         chk("frame_expected", (sbq.size() > 0), 1);
         if (sbq.size() == 0) begin
            n = 0;
            while (bus.txd !== 1'b1 && n < 400) begin @(negedge PCLK); n++; end
            continue;
         end
         e = sbq.pop_front();
         if (e.gap) chk("gapless_start", s, prev_end);
         cap  = '0;
         mask = '0;
         repeat (8) @(negedge PCLK);
         for (int k = 0; k < e.nchk; k++) begin
            cap[k]  = bus.txd;
            mask[k] = 1'b1;
            if (k < e.nchk - 1) repeat (16) @(negedge PCLK);
         end
         chk("frame_bits", cap & mask, e.bits & mask);
         if (e.abort) begin
            n = 0;
            while (bus.txd !== 1'b1 && n < 400) begin @(negedge PCLK); n++; end
            chk("abort_line_idle", bus.txd, 1'b1);
         end else begin
            repeat (7) @(negedge PCLK);
            chk("tx_done_at_stop_end", bus.tx_done, 1'b1);
            prev_end = s + 16 * e.len;
            @(negedge PCLK);
         end
      end
   end

   initial begin : stimulus
      int s;
      PRESETn            = 1'b0;
      bus.tx_en          = 1'b0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge PCLK);
      chk("rst_txd", bus.txd, 1'b1);
      chk("rst_busy", bus.tx_busy, 1'b0);
      chk("rst_done", bus.tx_done, 1'b0);
      chk("rst_pop", bus.fifo_pop, 1'b0);
      PRESETn = 1'b1;
      @(negedge PCLK);
      bus.tx_en = 1'b1;

      // 8N1 0x55; format changed mid-frame must not affect this frame.
      expect_frame(12'h2AA, 10, 10, 1'b0, 1'b0);
      push_word(8'h55);
      wait_start(s);
      set_cfg(4'd5, 1'b1, 1'b1, 1'b1);
      wait_dones(1);
      chk("pops_t1", pop_cnt, 1);
      chk("busy_t1", bus.tx_busy, 1'b0);

      // 7E2 0x83: bit 7 dropped, even parity 0, two stops.
      set_cfg(4'd7, 1'b1, 1'b0, 1'b1);
      expect_frame(12'h606, 11, 11, 1'b0, 1'b0);
      push_word(8'h83);
      wait_dones(2);
      chk("pops_t2", pop_cnt, 2);

      // 5O1 requested as 3 bits, 0x1F: odd parity 0.
      set_cfg(4'd3, 1'b1, 1'b1, 1'b0);
      expect_frame(12'h0BE, 8, 8, 1'b0, 1'b0);
      push_word(8'h1F);
      wait_dones(3);
      chk("pops_t3", pop_cnt, 3);

      // Back-to-back 8N1 0xA5, 0x3C.
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      expect_frame(12'h34A, 10, 10, 1'b0, 1'b0);
      expect_frame(12'h278, 10, 10, 1'b1, 1'b0);
      push_word(8'hA5);
      push_word(8'h3C);
      wait_dones(5);
      chk("pops_t4", pop_cnt, 5);
      chk("busy_t4", bus.tx_busy, 1'b0);

      // Reset during data bit 3 of 0xF0.
      expect_frame(12'h3E0, 10, 4, 1'b0, 1'b1);
      push_word(8'hF0);
      wait_start(s);
      repeat (68) @(negedge PCLK);
      chk("pre_reset_txd", bus.txd, 1'b0);
      PRESETn = 1'b0;
      #1;
      chk("arst_txd", bus.txd, 1'b1);
      chk("arst_busy", bus.tx_busy, 1'b0);
      chk("arst_done", bus.tx_done, 1'b0);
      chk("arst_pop", bus.fifo_pop, 1'b0);
      repeat (3) @(negedge PCLK);
      PRESETn = 1'b1;
      chk("no_done_on_abort", done_cnt, 5);
      expect_frame(12'h2B4, 10, 10, 1'b0, 1'b0);
      push_word(8'h5A);
      wait_dones(6);
      chk("pops_t5", pop_cnt, 7);

      // 6O1, tx_en dropped mid-frame with a word held.
      set_cfg(4'd6, 1'b1, 1'b1, 1'b0);
      expect_frame(12'h1DA, 9, 9, 1'b0, 1'b0);
      expect_frame(12'h1FE, 9, 9, 1'b1, 1'b0);
      expect_frame(12'h102, 9, 9, 1'b0, 1'b0);
      push_word(8'h2D);
      push_word(8'h3F);
      push_word(8'h01);
      wait_start(s);
      repeat (20) @(negedge PCLK);
      bus.tx_en = 1'b0;
      chk("pops_t6_held", pop_cnt, 9);
      wait_dones(8);
      repeat (20) @(negedge PCLK);
      chk("pops_t6_disabled", pop_cnt, 9);
      chk("fifo_kept_word", bus.fifo_empty, 1'b0);
      chk("busy_t6", bus.tx_busy, 1'b0);
      bus.tx_en = 1'b1;
      wait_dones(9);
      chk("pops_t6_final", pop_cnt, 10);

      repeat (4) @(negedge PCLK);
      mon_stop = 1'b1;
      repeat (2) @(negedge PCLK);
      chk("scoreboard_drained", sbq.size(), 0);
      chk("pops_while_disabled", bad_pop, 0);
      chk("done_total", done_cnt, 9);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
